// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio path (DAC serializer, later the ADC receiver).
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BCLKS = 64;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers; full/empty come straight from the pointers.
module sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// WM8731 left-justified DAC serializer: bit-clock master, mono sample sent on both channels.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 32,
  parameter int BCLK_HALF  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          mute,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          AUD_BCLK,
  output logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(FRAME_BCLKS / 2);

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] frame_reg;
  logic [SAMPLE_W-1:0] shift_reg;
  logic                frame_uf;

  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                push;
  logic                pop;
  logic                half_done;
  logic                fall_event;
  logic                slot_end;
  logic                frame_start;
  logic                right_start;
  logic [SAMPLE_W-1:0] left_word;
  logic [SAMPLE_W-1:0] right_word;

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (sample_in),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .head  (fifo_head)
  );

  assign sample_ready = !fifo_full;
  assign push         = sample_valid && !fifo_full;
  assign half_done    = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign fall_event   = half_done && AUD_BCLK;
  assign slot_end     = (bit_cnt == BIT_W'(SLOT_BITS - 1));
  assign frame_start  = fall_event && ((state == IDLE) || ((state == RIGHT) && slot_end));
  assign right_start  = fall_event && (state == LEFT) && slot_end;
  assign pop          = frame_start && !fifo_empty;
  // An underflowed frame keeps the stale frame_reg, so frame_uf must silence the right slot too.
  assign left_word    = (mute || fifo_empty) ? '0 : fifo_head;
  assign right_word   = (mute || frame_uf)   ? '0 : frame_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt  <= '0;
      AUD_BCLK <= 1'b0;
    end else if (half_done) begin
      div_cnt  <= '0;
      AUD_BCLK <= ~AUD_BCLK;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Everything codec-facing moves on BCLK falls so the codec samples mid-bit on the rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      frame_reg   <= '0;
      shift_reg   <= '0;
      frame_uf    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (frame_start) begin
        state       <= LEFT;
        bit_cnt     <= '0;
        AUD_DACLRCK <= 1'b1;
        shift_reg   <= left_word;
        AUD_DACDAT  <= left_word[SAMPLE_W-1];
        frame_uf    <= fifo_empty;
        underflow   <= fifo_empty;
        if (!fifo_empty) frame_reg <= fifo_head;
      end else if (right_start) begin
        state       <= RIGHT;
        bit_cnt     <= '0;
        AUD_DACLRCK <= 1'b0;
        shift_reg   <= right_word;
        AUD_DACDAT  <= right_word[SAMPLE_W-1];
      end else if (fall_event && (state != IDLE)) begin
        bit_cnt     <= bit_cnt + BIT_W'(1);
        shift_reg   <= shift_reg << 1;
        AUD_DACDAT  <= shift_reg[SAMPLE_W-2];
      end
    end
  end

endmodule
